// File: rtl/axis_burst_arb_pkg.sv
// Shared FSM encodings, default sizes and the width helper for the burst arbiter.
// Consumers: axis_burst_arb (top) and arb_rr_pick (round-robin search).
package axis_burst_arb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_t;

    localparam int DEF_NUM_PORTS  = 4;
    localparam int DEF_DATA_WIDTH = 128;

    // Number of bits needed to hold 'value' (minimum 1), used to size port indices.
    function automatic int log2(input int value);
        int w;
        w = 1;
        for (int i = 0; i < 31; i++) begin
            if ((value >> i) != 0) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/axis_burst_arb_rr_pick.sv
// Combinational round-robin search: first requester strictly after last_grant,
// wrapping around, so the previous winner is considered last.
module arb_rr_pick
    import axis_burst_arb_pkg::*;
#(
    parameter int NUM_PORTS  = DEF_NUM_PORTS,
    parameter int PORT_WIDTH = log2(NUM_PORTS - 1)
) (
    input  logic [NUM_PORTS-1:0]  req,
    input  logic [PORT_WIDTH-1:0] last_grant,
    output logic [PORT_WIDTH-1:0] grant,
    output logic                  grant_valid
);

    int                  cand;
    logic [PORT_WIDTH-1:0] cand_idx;

    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        cand        = 0;
        cand_idx    = '0;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            cand = int'(last_grant) + i;
            if (cand >= NUM_PORTS) cand = cand - NUM_PORTS;
            cand_idx = PORT_WIDTH'(cand);
            if (!grant_valid && req[cand_idx]) begin
                grant_valid = 1'b1;
                grant       = cand_idx;
            end
        end
    end

endmodule

// File: rtl/axis_burst_arb.sv
// Burst-granular round-robin merge of NUM_PORTS AXI-stream sources into one registered stream.
// Optional macro AXIS_BURST_ARB_TUSER_EN adds m_axis_tuser carrying the source port of each beat.
module axis_burst_arb
    import axis_burst_arb_pkg::*;
#(
    parameter int NUM_PORTS  = DEF_NUM_PORTS,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int PORT_WIDTH = log2(NUM_PORTS - 1)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_PORTS-1:0]            s_axis_tvalid,
    output logic [NUM_PORTS-1:0]            s_axis_tready,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_PORTS-1:0]            s_axis_tlast,
`ifdef AXIS_BURST_ARB_TUSER_EN
    output logic [PORT_WIDTH-1:0]           m_axis_tuser,
`endif
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic [DATA_WIDTH-1:0]           m_axis_tdata,
    output logic                            m_axis_tlast
);

    state_t                state;
    logic [PORT_WIDTH-1:0] grant;
    logic [PORT_WIDTH-1:0] last_grant;
    logic [PORT_WIDTH-1:0] pick_idx;
    logic                  pick_vld;
    logic                  out_free;
    logic                  accept;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  sel_valid;
    logic                  sel_last;

    arb_rr_pick #(
        .NUM_PORTS  (NUM_PORTS),
        .PORT_WIDTH (PORT_WIDTH)
    ) u_pick (
        .req         (s_axis_tvalid),
        .last_grant  (last_grant),
        .grant       (pick_idx),
        .grant_valid (pick_vld)
    );

    // The output register can take a beat when empty or draining this cycle.
    assign out_free  = ~m_axis_tvalid | m_axis_tready;
    assign sel_data  = s_axis_tdata[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
    assign sel_valid = s_axis_tvalid[grant];
    assign sel_last  = s_axis_tlast[grant];
    assign accept    = (state == ST_XFER) && sel_valid && out_free;

    always_comb begin
        s_axis_tready = '0;
        if (state == ST_XFER) s_axis_tready[grant] = out_free;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            grant         <= '0;
            last_grant    <= PORT_WIDTH'(NUM_PORTS - 1);
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tdata  <= '0;
`ifdef AXIS_BURST_ARB_TUSER_EN
            m_axis_tuser  <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_vld) begin
                        grant <= pick_idx;
                        state <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    // Grant is held until the tlast beat, even across source valid gaps.
                    if (accept && sel_last) begin
                        state      <= ST_IDLE;
                        last_grant <= grant;
                    end
                end
            endcase

            if (accept) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= sel_data;
                m_axis_tlast  <= sel_last;
`ifdef AXIS_BURST_ARB_TUSER_EN
                m_axis_tuser  <= grant;
`endif
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axis_burst_arb.sv
// Directed bench for axis_burst_arb (4 ports, 128-bit data); source beats carry {port, burst, beat}.
// Define AXIS_BURST_ARB_TUSER_EN for both files to also exercise m_axis_tuser.
module tb_axis_burst_arb;

    localparam int NP = 4;
    localparam int DW = 128;

    logic              clk = 1'b0;
    logic              rst;
    logic [NP-1:0]     s_axis_tvalid;
    logic [NP-1:0]     s_axis_tready;
    logic [NP*DW-1:0]  s_axis_tdata;
    logic [NP-1:0]     s_axis_tlast;
    logic              m_axis_tvalid;
    logic              m_axis_tready;
    logic [DW-1:0]     m_axis_tdata;
    logic              m_axis_tlast;
`ifdef AXIS_BURST_ARB_TUSER_EN
    logic [1:0]        m_axis_tuser;
`endif

    always #5 clk = ~clk;

    axis_burst_arb #(.NUM_PORTS(NP), .DATA_WIDTH(DW)) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tlast  (s_axis_tlast),
`ifdef AXIS_BURST_ARB_TUSER_EN
        .m_axis_tuser  (m_axis_tuser),
`endif
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int src_len [NP];
    int src_bursts [NP];
    int src_rem [NP];
    int src_beat [NP];
    int src_bn [NP];
    bit src_hold [NP];

    int          lg_cyc [$];
    logic [31:0] lg_dat [$];
    logic        lg_last [$];
    logic [7:0]  lg_usr [$];

    bit          stall_pending;
    logic [DW-1:0] stall_data;
    logic        stall_last;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic update_srcs();
        for (int p = 0; p < NP; p++) begin
            if (src_rem[p] == 0 && src_bursts[p] > 0) begin
                src_rem[p]  = src_len[p];
                src_beat[p] = 0;
                src_bn[p]   = src_bn[p] + 1;
                src_bursts[p]--;
            end
            s_axis_tvalid[p] = (src_rem[p] > 0) && !src_hold[p];
            s_axis_tlast[p]  = (src_rem[p] == 1);
            s_axis_tdata[p*DW +: DW] = {96'd0, 8'(p), 8'(src_bn[p]), 16'(src_beat[p])};
        end
    endtask

    // One clock: sample handshakes before the edge, advance sources after it.
    task automatic tick();
        logic [NP-1:0] s_acc;
        #1;
        s_acc = s_axis_tvalid & s_axis_tready;
        if (stall_pending) begin
            chk("stall_vld", 64'(m_axis_tvalid), 64'd1);
            chk("stall_data", m_axis_tdata[63:0], stall_data[63:0]);
            chk("stall_last", 64'(m_axis_tlast), 64'(stall_last));
        end
        stall_pending = m_axis_tvalid && !m_axis_tready;
        stall_data    = m_axis_tdata;
        stall_last    = m_axis_tlast;
        if (m_axis_tvalid && m_axis_tready) begin
            lg_cyc.push_back(cyc);
            lg_dat.push_back(m_axis_tdata[31:0]);
            lg_last.push_back(m_axis_tlast);
`ifdef AXIS_BURST_ARB_TUSER_EN
            lg_usr.push_back(8'(m_axis_tuser));
`else
            lg_usr.push_back(8'd0);
`endif
        end
        @(posedge clk);
        for (int p = 0; p < NP; p++) begin
            if (s_acc[p]) begin
                src_beat[p]++;
                src_rem[p]--;
            end
        end
        cyc++;
        @(negedge clk);
        update_srcs();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        m_axis_tready = 1'b1;
        for (int p = 0; p < NP; p++) begin
            src_len[p] = 0; src_bursts[p] = 0; src_rem[p] = 0;
            src_beat[p] = 0; src_bn[p] = 0; src_hold[p] = 1'b0;
        end
        update_srcs();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("rst_m_tlast", 64'(m_axis_tlast), 64'd0);
        chk("rst_m_tdata_zero", 64'(m_axis_tdata == '0), 64'd1);
        chk("rst_s_tready", 64'(s_axis_tready), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        stall_pending = 1'b0;
        lg_cyc.delete(); lg_dat.delete(); lg_last.delete(); lg_usr.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        m_axis_tready = 1'b1;
        s_axis_tvalid = '0;
        s_axis_tlast  = '0;
        s_axis_tdata  = '0;
        stall_pending = 1'b0;

        // Ports 0 and 2, 4-beat bursts each: port 0 first, one idle gap, then port 2.
        do_reset();
        src_len[0] = 4; src_bursts[0] = 1;
        src_len[2] = 4; src_bursts[2] = 1;
        update_srcs();
        repeat (14) tick();
        chk("t28_count", 64'(lg_dat.size()), 64'd8);
        if (lg_dat.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                chk("t28_cycle", 64'(lg_cyc[i]), 64'((i < 4) ? i + 2 : i + 3));
                chk("t28_port", 64'(lg_dat[i][31:24]), 64'((i < 4) ? 0 : 2));
                chk("t28_beat", 64'(lg_dat[i][15:0]), 64'(i % 4));
                chk("t28_last", 64'(lg_last[i]), 64'((i % 4) == 3));
            end
        end

        // All four ports streaming 2-beat bursts: bursts granted 0,1,2,3,0,1,2,3.
        do_reset();
        for (int p = 0; p < NP; p++) begin
            src_len[p] = 2; src_bursts[p] = 2;
        end
        update_srcs();
        for (int t = 0; t < 60 && lg_dat.size() < 16; t++) tick();
        chk("t29_count", 64'(lg_dat.size()), 64'd16);
        if (lg_dat.size() == 16) begin
            for (int b = 0; b < 8; b++) begin
                chk("t29_order", 64'(lg_dat[2*b][31:24]), 64'(b % 4));
                chk("t29_burst_no", 64'(lg_dat[2*b][23:16]), 64'((b / 4) + 1));
                chk("t29_last", 64'(lg_last[2*b+1]), 64'd1);
            end
        end

        // 32-beat burst on port 1 with m_axis_tready pattern 1,0,0,1.
        do_reset();
        src_len[1] = 32; src_bursts[1] = 1;
        update_srcs();
        for (int t = 0; t < 300 && lg_dat.size() < 32; t++) begin
            m_axis_tready = ((t % 4) == 0) || ((t % 4) == 3);
            tick();
        end
        m_axis_tready = 1'b1;
        chk("t30_count", 64'(lg_dat.size()), 64'd32);
        if (lg_dat.size() == 32) begin
            for (int i = 0; i < 32; i++) begin
                chk("t30_data", 64'(lg_dat[i]), 64'(32'h0101_0000 + i));
                chk("t30_last", 64'(lg_last[i]), 64'(i == 31));
            end
        end

        // Port 1 (6 beats) pauses for 3 cycles after 2 beats; port 3 must wait.
        do_reset();
        src_len[1] = 6; src_bursts[1] = 1;
        src_len[3] = 2; src_bursts[3] = 1;
        update_srcs();
        repeat (3) tick();
        src_hold[1] = 1'b1;
        update_srcs();
        for (int t = 0; t < 3; t++) begin
            #1;
            chk("t31_rdy3_held", 64'(s_axis_tready[3]), 64'd0);
            chk("t31_rdy1_open", 64'(s_axis_tready[1]), 64'd1);
            tick();
        end
        src_hold[1] = 1'b0;
        update_srcs();
        for (int t = 0; t < 40 && lg_dat.size() < 8; t++) tick();
        chk("t31_count", 64'(lg_dat.size()), 64'd8);
        if (lg_dat.size() == 8) begin
            for (int i = 0; i < 8; i++)
                chk("t31_port", 64'(lg_dat[i][31:24]), 64'((i < 6) ? 1 : 3));
            chk("t31_p1_last", 64'(lg_last[5]), 64'd1);
        end

        // Reset during beat 10 of a 32-beat port 2 burst; port 0 wins afterwards.
        do_reset();
        src_len[2] = 32; src_bursts[2] = 1;
        update_srcs();
        repeat (11) tick();
        chk("t32_pre_count", 64'(lg_dat.size()), 64'd9);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        src_len[0] = 2; src_bursts[0] = 1;
        update_srcs();
        #1;
        chk("t32_tvalid_after_rst", 64'(m_axis_tvalid), 64'd0);
        chk("t32_count_at_rst", 64'(lg_dat.size()), 64'd10);
        for (int t = 0; t < 20 && lg_dat.size() < 11; t++) tick();
        chk("t32_post_count", 64'(lg_dat.size() >= 11), 64'd1);
        if (lg_dat.size() >= 11) begin
            chk("t32_next_port", 64'(lg_dat[10][31:24]), 64'd0);
            chk("t32_next_cycle", 64'(lg_cyc[10]), 64'd14);
        end

`ifdef AXIS_BURST_ARB_TUSER_EN
        // Port 3 burst: every beat tagged with tuser = 3.
        do_reset();
        src_len[3] = 3; src_bursts[3] = 1;
        update_srcs();
        repeat (10) tick();
        chk("t33_count", 64'(lg_usr.size()), 64'd3);
        for (int i = 0; i < lg_usr.size(); i++)
            chk("t33_tuser", 64'(lg_usr[i]), 64'd3);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
